maxnet_host_ctrl: RTL and testbench
===================================

Name: maxnet_host_ctrl

Overview:
Initiator-side controller for the Maxnet core's start/done/maxnumber interface. It takes input vectors from an upstream stream, loads them into the core's input registers and raises start. It then waits for done, captures maxnumber and presents it downstream as a valid/ready result. This replaces bench-driven stimulus when the Maxnet core is embedded in a larger datapath.

Parameters:
WIDTH, 32, bit width of each input element and of maxnumber
NUM_INPUTS, 4, elements per Maxnet job
TIMEOUT_CYCLES, 4096, maximum cycles to wait for core_done before aborting the job

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream element valid
in_ready  out  1  controller accepts an element
in_data  in  WIDTH  input element
in_last  in  1  final element of a job
core_rst  out  1  one-cycle reset pulse to the core
core_ld_en  out  1  write strobe into core input registers
core_ld_addr  out  clog2(NUM_INPUTS)  core input register index
core_ld_data  out  WIDTH  value written
core_start  out  1  start request to the core
core_done  in  1  core completion
core_max  in  WIDTH  core maxnumber result
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  captured maximum (0 on timeout)
res_timeout  out  1  qualifies res_data: job aborted
busy  out  1  high in every state except IDLE
job_count  out  16  completed jobs (normal and timeout), wraps at 2^16

Behaviour:
- Reset: synchronous; rst=1 at a rising edge forces state IDLE. All outputs go to 0 that cycle: in_ready, core_*, res_*, busy, job_count, and the element/timeout counters. Reset mid-job aborts silently: no result is produced and core_rst is not pulsed.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) moves to LOAD and is processed as element 0.
- LOAD: in_ready=1. Each handshake drives core_ld_en=1, core_ld_addr=idx, core_ld_data=in_data combinationally, then idx increments.
  - Job ends when in_last arrives or idx reaches NUM_INPUTS-1, whichever comes first.
  - Early in_last: the remaining indices are zero-filled, one per cycle, with in_ready=0.
  - No in_last at idx=NUM_INPUTS-1: the job still ends; following elements start the next job.
  - Then go to START.
- START: core_start=1 and the timeout counter is cleared. Next cycle go to WAIT.
- WAIT: core_start stays 1 (level request held until done). Timeout counter increments each cycle.
  - core_done=1 sampled: register core_max into res_data, res_timeout=0, drop core_start, go to RESULT.
  - Counter reaches TIMEOUT_CYCLES-1 without done: res_data=0, res_timeout=1, drop core_start, pulse core_rst for one cycle, go to RESULT.
  - core_done and timeout in the same cycle: done wins.
- RESULT: res_valid=1. res_data and res_timeout are stable while res_valid&!res_ready. On res_valid&res_ready: job_count increments, go to IDLE.
- Latency: with in_valid held and res_ready=1, the minimum from the first element to res_valid is NUM_INPUTS+2+core latency cycles.
- No overlap: in_ready=0 in START/WAIT/RESULT, so one job is in flight at a time.
- core_done is level-sampled only in WAIT; done asserted in any other state is ignored.

Decomposition:
- Shared package maxnet_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT, RESULT)
  - WIDTH and NUM_INPUTS defaults, so the core and this controller agree
  - TIMEOUT_CYCLES default
- One natural sub-module: maxnet_timeout_cnt, a loadable up-counter with clear, enable and terminal-count flag. The FSM and load index stay in the top.

Test Plan:
- Normal job: stream 3F800000, 40400000, 40000000, 3F000000 with in_last on the 4th; core model asserts done 10 cycles after start, core_max=40400000 -> ld_addr 0..3 with matching data, core_start high until done, res_data=40400000, res_timeout=0, job_count=1.
- Early last: 2 elements 41200000, 40A00000, in_last on the 2nd -> addr 2,3 written with 0 and in_ready=0 during fill; result 41200000.
- Timeout: core never asserts done, TIMEOUT_CYCLES=16 -> core_rst one-cycle pulse 16 cycles after START, res_valid with res_data=0, res_timeout=1, job_count=1.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_data stable, in_ready=0, no new loads; res_ready=1 -> IDLE next cycle.
- Reset mid-WAIT: rst=1 for one cycle while waiting -> all outputs 0 next cycle, job_count=0, no res_valid; a following job completes normally.
- Back-to-back: 8 elements without in_last -> two jobs run sequentially, job_count=2, results in order.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet core and its host-side controller.
// Holds the job geometry defaults so the core and the controller are built to the same
// element count and width. Also holds the controller state encoding.
package maxnet_pkg;

  localparam int MAXNET_WIDTH          = 32;
  localparam int MAXNET_NUM_INPUTS     = 4;
  localparam int MAXNET_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } maxnet_state_e;

endpackage

// File: rtl/maxnet_timeout_cnt.sv
// Purpose: loadable up-counter with clear, enable and terminal-count flag (job watchdog).
// Latency: count updates one cycle after clr_i/load_i/en_i; tc_o is a decode of the current count.
// Backpressure: none; it counts whenever en_i is high.
// Ports: clk_i/rst_i (sync, active high), clr_i (priority), load_i/load_val_i, en_i;
//        tc_o is high while the count sits one below LIMIT, so the next increment reaches LIMIT.
module maxnet_timeout_cnt #(
  parameter int LIMIT = 4095,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/maxnet_host_ctrl.sv
// Purpose: loads a job of input elements into the Maxnet core, starts it, returns maxnumber.
// Latency: first element to res_valid is NUM_INPUTS + 2 + core latency cycles at minimum.
// Backpressure: in_ready low outside IDLE/LOAD and during zero-fill; result held until res_ready.
// Ports: in_* upstream element stream; core_* load/start/done/reset interface of the core;
//        res_* downstream result (res_timeout marks an aborted job); busy, job_count status.
module maxnet_host_ctrl
  import maxnet_pkg::*;
#(
  parameter int WIDTH          = MAXNET_WIDTH,
  parameter int NUM_INPUTS     = MAXNET_NUM_INPUTS,
  parameter int TIMEOUT_CYCLES = MAXNET_TIMEOUT_CYCLES,
  localparam int AW            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             core_rst,
  output logic             core_ld_en,
  output logic [AW-1:0]    core_ld_addr,
  output logic [WIDTH-1:0] core_ld_data,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_max,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout,
  output logic             busy,
  output logic [15:0]      job_count
);

  maxnet_state_e    state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             fill_q, fill_d;        // zero-filling the tail after an early in_last
  logic             in_ready_q, in_ready_d;
  logic             start_q, start_d;
  logic             core_rst_q, core_rst_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_to_q, res_to_d;
  logic             busy_q, busy_d;
  logic [15:0]      job_q, job_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             hs, last_idx;

  maxnet_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES - 1)) u_timeout (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  // in_ready is registered and only high in IDLE/LOAD, so hs can only fire there.
  assign hs       = in_valid & in_ready_q;
  assign last_idx = (idx_q == AW'(NUM_INPUTS - 1));

  // Load strobe follows the handshake in the same cycle; zero-fill writes need no input.
  assign core_ld_en   = hs | fill_q;
  assign core_ld_addr = idx_q;
  assign core_ld_data = hs ? in_data : '0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    start_d     = start_q;
    core_rst_d  = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_to_d    = res_to_q;
    job_d       = job_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (fill_q || hs) begin
          if (last_idx) begin
            state_d = ST_START;
            idx_d   = '0;
            fill_d  = 1'b0;
            start_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 1'b1;
            if (hs && in_last) fill_d = 1'b1;
          end
        end
      end
      ST_START: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // done takes priority over a coincident timeout
        if (core_done) begin
          res_data_d  = core_max;
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = ST_RESULT;
        end else if (cnt_tc) begin
          res_data_d  = '0;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          start_d     = 1'b0;
          core_rst_d  = 1'b1;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_d       = job_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE) || ((state_d == ST_LOAD) && !fill_d);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      fill_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      core_rst_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_to_q    <= 1'b0;
      busy_q      <= 1'b0;
      job_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      core_rst_q  <= core_rst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_to_q    <= res_to_d;
      busy_q      <= busy_d;
      job_q       <= job_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign core_start  = start_q;
  assign core_rst    = core_rst_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;
  assign busy        = busy_q;
  assign job_count   = job_q;

endmodule

// File: tb/tb_maxnet_host_ctrl.sv
// Purpose: directed self-checking bench for maxnet_host_ctrl with a scripted core.
// Latency: inputs change on the falling edge; registered outputs are sampled there,
//          load-port outputs 1 time unit after the inputs change.
module tb_maxnet_host_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        core_rst;
  logic        core_ld_en;
  logic [1:0]  core_ld_addr;
  logic [31:0] core_ld_data;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [31:0] core_max = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        busy;
  logic [15:0] job_count;

  int n_cmp = 0;
  int n_bad = 0;

  maxnet_host_ctrl #(.WIDTH(32), .NUM_INPUTS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_rst(core_rst), .core_ld_en(core_ld_en), .core_ld_addr(core_ld_addr),
    .core_ld_data(core_ld_data), .core_start(core_start), .core_done(core_done),
    .core_max(core_max), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of reset, check everything cleared, release; in_ready rises one cycle later.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_rst", core_rst, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic send_el(input logic [31:0] d, input logic last, input logic [1:0] addr);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("el_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    chk("ld_en", core_ld_en, 1);
    chk("ld_addr", core_ld_addr, addr);
    chk("ld_data", core_ld_data, d);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Core raises done dly cycles after the START cycle; result expected the cycle after.
  task automatic finish_job(input int dly, input logic [31:0] mx);
    int k;
    int hi;
    int rv;
    k = 0;
    while (core_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("start_seen", core_start, 1);
    hi = 0;
    rv = 0;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (core_start === 1'b1) hi++;
      if (res_valid === 1'b1) rv++;
    end
    chk("start_held", hi, dly);
    chk("no_early_res", rv, 0);
    core_done = 1'b1;
    core_max  = mx;
    tick();
    core_done = 1'b0;
    core_max  = '0;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, mx);
    chk("res_timeout", res_timeout, 0);
    chk("start_drop", core_start, 0);
  endtask

  task automatic accept(input int exp_jobs);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("acc_res_valid", res_valid, 0);
    chk("acc_job_count", job_count, exp_jobs);
    chk("acc_in_ready", in_ready, 1);
    chk("acc_busy", busy, 0);
  endtask

  initial begin
    int bad;
    int first_rst;
    int rst_cnt;
    int rv_cnt;

    // Normal job
    do_reset();
    send_el(32'h3F800000, 1'b0, 2'd0);
    chk("load_busy", busy, 1);
    send_el(32'h40400000, 1'b0, 2'd1);
    send_el(32'h40000000, 1'b0, 2'd2);
    send_el(32'h3F000000, 1'b1, 2'd3);
    chk("start_in_ready", in_ready, 0);
    finish_job(10, 32'h40400000);
    accept(1);

    // Early last: tail zero-filled with in_ready low even while in_valid is offered
    do_reset();
    send_el(32'h41200000, 1'b0, 2'd0);
    send_el(32'h40A00000, 1'b1, 2'd1);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    #1;
    chk("fill2_in_ready", in_ready, 0);
    chk("fill2_ld_en", core_ld_en, 1);
    chk("fill2_addr", core_ld_addr, 2);
    chk("fill2_data", core_ld_data, 0);
    tick();
    #1;
    chk("fill3_in_ready", in_ready, 0);
    chk("fill3_ld_en", core_ld_en, 1);
    chk("fill3_addr", core_ld_addr, 3);
    chk("fill3_data", core_ld_data, 0);
    tick();
    #1;
    chk("fill_done_ld_en", core_ld_en, 0);
    in_valid = 1'b0;
    finish_job(3, 32'h41200000);
    accept(1);

    // Timeout: core never answers; core_rst pulses 16 cycles after START
    do_reset();
    send_el(32'h00000001, 1'b0, 2'd0);
    send_el(32'h00000002, 1'b0, 2'd1);
    send_el(32'h00000003, 1'b0, 2'd2);
    send_el(32'h00000004, 1'b1, 2'd3);
    chk("to_start", core_start, 1);
    first_rst = 0;
    rst_cnt   = 0;
    rv_cnt    = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (core_rst === 1'b1) begin
        rst_cnt++;
        if (first_rst == 0) first_rst = k;
      end
      if (res_valid === 1'b1) rv_cnt++;
      if (k == 16) begin
        chk("to_res_valid", res_valid, 1);
        chk("to_res_data", res_data, 0);
        chk("to_res_timeout", res_timeout, 1);
        chk("to_start_drop", core_start, 0);
      end
    end
    chk("to_rst_cycle", first_rst, 16);
    chk("to_rst_width", rst_cnt, 1);
    chk("to_res_cycles", rv_cnt, 5);
    accept(1);

    // Backpressure: result held 20 cycles, no loads accepted meanwhile
    do_reset();
    send_el(32'h11111111, 1'b0, 2'd0);
    send_el(32'h12345678, 1'b0, 2'd1);
    send_el(32'h00000005, 1'b0, 2'd2);
    send_el(32'h00000006, 1'b1, 2'd3);
    finish_job(2, 32'h12345678);
    in_valid = 1'b1;
    in_data  = 32'h00000055;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== 32'h12345678 || res_timeout !== 1'b0 ||
          in_ready !== 1'b0 || core_ld_en !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_hold_errors", bad, 0);
    in_valid = 1'b0;
    accept(1);

    // Reset during WAIT aborts silently; done in IDLE is ignored; next job is clean
    do_reset();
    send_el(32'h00000010, 1'b0, 2'd0);
    send_el(32'h00000020, 1'b0, 2'd1);
    send_el(32'h00000030, 1'b0, 2'd2);
    send_el(32'h00000040, 1'b1, 2'd3);
    tick();
    tick();
    chk("mid_wait_start", core_start, 1);
    rst = 1'b1;
    tick();
    chk("abort_start", core_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_core_rst", core_rst, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_job_count", job_count, 0);
    rst = 1'b0;
    core_done = 1'b1;
    tick();
    tick();
    core_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_res", res_valid, 0);
    chk("idle_done_start", core_start, 0);
    send_el(32'hC0000000, 1'b0, 2'd0);
    send_el(32'h3F800000, 1'b0, 2'd1);
    send_el(32'h40E00000, 1'b0, 2'd2);
    send_el(32'h40000000, 1'b1, 2'd3);
    finish_job(5, 32'h40E00000);
    accept(1);

    // Back-to-back: 8 elements, no in_last, split into two jobs of four
    do_reset();
    send_el(32'h00000101, 1'b0, 2'd0);
    send_el(32'h00000102, 1'b0, 2'd1);
    send_el(32'h00000103, 1'b0, 2'd2);
    send_el(32'h00000104, 1'b0, 2'd3);
    finish_job(4, 32'h00000104);
    accept(1);
    send_el(32'h00000201, 1'b0, 2'd0);
    send_el(32'h00000202, 1'b0, 2'd1);
    send_el(32'h00000203, 1'b0, 2'd2);
    send_el(32'h00000204, 1'b0, 2'd3);
    finish_job(6, 32'h00000204);
    accept(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
